// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states, byte-enable masks.
package dmem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        REQ1,
        WAIT1,
        REQ2,
        WAIT2,
        DONE
    } state_t;

    // Size code 2'b11 is folded into a word access.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            MEM_BYTE: size_mask = BE_BYTE;
            MEM_HALF: size_mask = BE_HALF;
            default:  size_mask = BE_WORD;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            MEM_BYTE: size_bytes = 3'd1;
            MEM_HALF: size_bytes = 3'd2;
            default:  size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Lane steering for both access phases: store shift / byte enables and load extract / extend.
// Purely combinational, zero latency, no flow control.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        sz_ex_i,
    input  logic [1:0]  off_i,
    input  logic        second_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] word1_i,
    input  logic [31:0] word2_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [5:0]  sh;
    logic [3:0]  mask;
    logic [31:0] ld;

    assign sh   = {1'b0, off_i, 3'b000};
    assign mask = size_mask(size_i);

    always_comb begin
        // The second beat carries whatever spilled past the top lane of the first word.
        if (second_i) begin
            be_o    = mask >> (3'd4 - {1'b0, off_i});
            wdata_o = wdata_i >> (6'd32 - sh);
        end else begin
            be_o    = mask << off_i;
            wdata_o = wdata_i << sh;
        end

        ld = (word1_i >> sh) | (word2_i << (6'd32 - sh));

        case (size_i)
            MEM_BYTE: rdata_o = sz_ex_i ? {{24{ld[7]}}, ld[7:0]}   : {24'd0, ld[7:0]};
            MEM_HALF: rdata_o = sz_ex_i ? {{16{ld[15]}}, ld[15:0]} : {16'd0, ld[15:0]};
            default:  rdata_o = ld;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: req/gnt/rvalid sequencing, stall, aligned/extended load return.
// Word-crossing accesses are split when DMEM_MISALIGN_EN is defined, otherwise trapped via misalign_exc_out.
module dmem_ctrl
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en_in,
    input  logic        wr_en_in,
    input  logic [1:0]  mem_size_in,
    input  logic        sz_ex_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        stall_out,
    output logic [31:0] rdata_out,
    output logic        done_out,
    output logic        misalign_exc_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    state_t      state_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sz_ex_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word1_q;
    logic        split_q;

    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;
    logic        done_q;
    logic        exc_q;
    logic [31:0] rdata_q;

    logic        req_in;
    logic        idle;
    logic        split_in;
    logic        trap_in;
    logic [31:0] addr2;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;

    assign req_in = rd_en_in | wr_en_in;
    assign idle   = (state_q == IDLE);
    assign addr2  = {addr_q[31:2] + 30'd1, 2'b00};

`ifdef DMEM_MISALIGN_EN
    assign split_in = ({1'b0, addr_in[1:0]} + size_bytes(mem_size_in)) > 3'd4;
    assign trap_in  = 1'b0;
`else
    assign split_in = 1'b0;
    assign trap_in  = ((mem_size_in == MEM_HALF) && addr_in[0]) ||
                      (mem_size_in[1] && (addr_in[1:0] != 2'b00));
`endif

    // In IDLE the aligner prepares the first beat from the live inputs; afterwards it
    // works from the latched request to build the second beat and the load result.
    dmem_align u_align (
        .size_i   (idle ? mem_size_in : size_q),
        .sz_ex_i  (idle ? sz_ex_in : sz_ex_q),
        .off_i    (idle ? addr_in[1:0] : addr_q[1:0]),
        .second_i (!idle),
        .wdata_i  (idle ? wdata_in : wdata_q),
        .word1_i  ((state_q == WAIT1) ? mem_rdata : word1_q),
        .word2_i  ((state_q == WAIT2) ? mem_rdata : 32'd0),
        .be_o     (al_be),
        .wdata_o  (al_wdata),
        .rdata_o  (al_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            sz_ex_q     <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            word1_q     <= 32'd0;
            split_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            done_q      <= 1'b0;
            exc_q       <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            done_q  <= 1'b0;
            exc_q   <= 1'b0;
            rdata_q <= 32'd0;
            case (state_q)
                IDLE: begin
                    if (req_in) begin
                        we_q    <= wr_en_in;
                        size_q  <= mem_size_in;
                        sz_ex_q <= sz_ex_in;
                        addr_q  <= addr_in;
                        wdata_q <= wdata_in;
                        split_q <= split_in;
                        if (trap_in) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            exc_q   <= 1'b1;
                        end else begin
                            state_q     <= REQ1;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= wr_en_in;
                            mem_addr_q  <= {addr_in[31:2], 2'b00};
                            mem_be_q    <= al_be;
                            mem_wdata_q <= al_wdata;
                        end
                    end
                end
                REQ1: begin
                    if (mem_gnt) begin
                        if (we_q && split_q) begin
                            state_q     <= REQ2;
                            mem_addr_q  <= addr2;
                            mem_be_q    <= al_be;
                            mem_wdata_q <= al_wdata;
                        end else if (we_q) begin
                            state_q   <= DONE;
                            mem_req_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            state_q   <= WAIT1;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                WAIT1: begin
                    if (mem_rvalid) begin
                        word1_q <= mem_rdata;
                        if (split_q) begin
                            state_q     <= REQ2;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= addr2;
                            mem_be_q    <= al_be;
                            mem_wdata_q <= al_wdata;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            rdata_q <= al_rdata;
                        end
                    end
                end
                REQ2: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        if (we_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WAIT2;
                        end
                    end
                end
                WAIT2: begin
                    if (mem_rvalid) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        rdata_q <= al_rdata;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall_out        = req_in && (state_q != DONE);
    assign rdata_out        = rdata_q;
    assign done_out         = done_q;
    assign misalign_exc_out = exc_q;
    assign mem_req          = mem_req_q;
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_be           = mem_be_q;
    assign mem_wdata        = mem_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus randomized back-to-back traffic against a byte-level memory model.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en_in, wr_en_in, sz_ex_in;
    logic [1:0]  mem_size_in;
    logic [31:0] addr_in, wdata_in;
    logic        stall_out, done_out, misalign_exc_out;
    logic [31:0] rdata_out;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    dmem_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en_in(rd_en_in), .wr_en_in(wr_en_in), .mem_size_in(mem_size_in),
        .sz_ex_in(sz_ex_in), .addr_in(addr_in), .wdata_in(wdata_in),
        .stall_out(stall_out), .rdata_out(rdata_out), .done_out(done_out),
        .misalign_exc_out(misalign_exc_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // wmem is the memory the DUT talks to; bmem is the reference view kept byte by byte.
    logic [31:0] wmem [0:255];
    logic [7:0]  bmem [0:1023];

    int          r_done_cyc, r_ntr, r_req_cycles, r_viol;
    logic        r_exc;
    logic [31:0] r_rdata;
    logic [63:0] r_stall_bits;
    logic [31:0] tr_addr  [0:1];
    logic [3:0]  tr_be    [0:1];
    logic [31:0] tr_wdata [0:1];

    task automatic set_word(input logic [31:0] a, input logic [31:0] val);
        wmem[a[9:2]] = val;
        for (int i = 0; i < 4; i++) bmem[{a[9:2], 2'b00} + i] = val[8*i +: 8];
    endtask

    task automatic model_store(input logic [31:0] a, input int nb, input logic [31:0] wd);
        for (int i = 0; i < nb; i++) bmem[a[9:0] + i] = wd[8*i +: 8];
    endtask

    // Drives one access and plays the memory side; g = gnt wait cycles, r = rvalid delay after gnt.
    task automatic do_access(input logic we, input logic [1:0] sz, input logic sx,
                             input logic [31:0] a, input logic [31:0] wd, input int g, input int r);
        int cyc, wait_n, pend;
        logic seen_done;
        logic [7:0]  lat_idx;
        logic [68:0] hold;
        r_ntr = 0; r_req_cycles = 0; r_viol = 0; r_done_cyc = 0;
        r_exc = 1'b0; r_rdata = 32'd0; r_stall_bits = 64'd0;
        wr_en_in = we; rd_en_in = we ? 1'($urandom % 2) : 1'b1;
        mem_size_in = sz; sz_ex_in = sx; addr_in = a; wdata_in = wd;
        cyc = 0; wait_n = 0; pend = 0; seen_done = 1'b0; lat_idx = 8'd0; hold = '0;
        while (!seen_done && cyc < 60) begin
            cyc++;
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (stall_out !== !done_out) r_viol++;
            r_stall_bits[cyc-1] = stall_out;
            if (done_out === 1'b1) begin
                seen_done = 1'b1; r_done_cyc = cyc; r_exc = misalign_exc_out; r_rdata = rdata_out;
            end else if (rdata_out !== 32'd0 || misalign_exc_out !== 1'b0) begin
                r_viol++;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin mem_rvalid = 1'b1; mem_rdata = wmem[lat_idx]; end
            end
            if (mem_req === 1'b1) begin
                r_req_cycles++;
                if (wait_n == 0) hold = {mem_we, mem_addr, mem_be, mem_wdata};
                else if (hold !== {mem_we, mem_addr, mem_be, mem_wdata}) r_viol++;
                if (wait_n == g) begin
                    mem_gnt = 1'b1; wait_n = 0;
                    if (r_ntr < 2) begin
                        tr_addr[r_ntr] = mem_addr; tr_be[r_ntr] = mem_be; tr_wdata[r_ntr] = mem_wdata;
                    end else r_viol++;
                    r_ntr++;
                    if (mem_we !== we) r_viol++;
                    if (mem_we === 1'b1) begin
                        for (int i = 0; i < 4; i++)
                            if (mem_be[i]) wmem[mem_addr[9:2]][8*i +: 8] = mem_wdata[8*i +: 8];
                    end else begin
                        pend = r; lat_idx = mem_addr[9:2];
                    end
                end else wait_n++;
            end
        end
        @(posedge clk); #1;
        rd_en_in = 1'b0; wr_en_in = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rd_en_in = 0; wr_en_in = 0; mem_size_in = 0; sz_ex_in = 0; addr_in = 0; wdata_in = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        #2;
        n_checks++;
        if ({stall_out, done_out, misalign_exc_out, rdata_out, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== '0)
            $display("FAIL reset_outputs got req=%b we=%b addr=%h be=%b wd=%h done=%b exc=%b rd=%h stall=%b want all 0",
                     mem_req, mem_we, mem_addr, mem_be, mem_wdata, done_out, misalign_exc_out, rdata_out, stall_out);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_aligned_load();
        set_word(32'h100, 32'hDEADBEEF);
        do_access(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 0, 1);
        n_checks++; if (r_rdata !== 32'hDEADBEEF) $display("FAIL lw_rdata got %h want deadbeef", r_rdata); else n_pass++;
        n_checks++; if (r_done_cyc !== 4) $display("FAIL lw_done_cycle got %0d want 4", r_done_cyc); else n_pass++;
        n_checks++; if (r_stall_bits[3:0] !== 4'b0111) $display("FAIL lw_stall got %b want 0111", r_stall_bits[3:0]); else n_pass++;
        n_checks++;
        if (r_ntr !== 1 || tr_addr[0] !== 32'h100 || tr_be[0] !== 4'b1111 || r_viol !== 0)
            $display("FAIL lw_bus got ntr=%0d addr=%h be=%b viol=%0d want 1/100/1111/0", r_ntr, tr_addr[0], tr_be[0], r_viol);
        else n_pass++;
    endtask

    task automatic test_byte_extend();
        set_word(32'h100, 32'h80FF0000);
        do_access(1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 0, 2);
        n_checks++; if (r_rdata !== 32'hFFFFFF80) $display("FAIL lb_sext got %h want ffffff80", r_rdata); else n_pass++;
        n_checks++; if (tr_be[0] !== 4'b1000) $display("FAIL lb_be got %b want 1000", tr_be[0]); else n_pass++;
        do_access(1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 1, 1);
        n_checks++; if (r_rdata !== 32'h00000080) $display("FAIL lb_zext got %h want 00000080", r_rdata); else n_pass++;
        n_checks++; if (r_done_cyc !== 5) $display("FAIL lb_zext_cycle got %0d want 5", r_done_cyc); else n_pass++;
    endtask

    task automatic test_half_store();
        do_access(1'b1, 2'b01, 1'b0, 32'h202, 32'h00001234, 2, 1);
        model_store(32'h202, 2, 32'h00001234);
        n_checks++; if (tr_be[0] !== 4'b1100) $display("FAIL sh_be got %b want 1100", tr_be[0]); else n_pass++;
        n_checks++; if (tr_wdata[0] !== 32'h12340000) $display("FAIL sh_wdata got %h want 12340000", tr_wdata[0]); else n_pass++;
        n_checks++; if (r_req_cycles !== 3) $display("FAIL sh_req_cycles got %0d want 3", r_req_cycles); else n_pass++;
        n_checks++;
        if (r_done_cyc !== 5 || r_viol !== 0) $display("FAIL sh_done got cyc=%0d viol=%0d want 5/0", r_done_cyc, r_viol);
        else n_pass++;
    endtask

    task automatic test_misaligned_store();
        do_access(1'b1, 2'b10, 1'b0, 32'h301, 32'hAABBCCDD, 0, 1);
`ifdef DMEM_MISALIGN_EN
        model_store(32'h301, 4, 32'hAABBCCDD);
        n_checks++;
        if (r_ntr !== 2 || r_done_cyc !== 4 || r_exc !== 1'b0)
            $display("FAIL sw_split_beats got ntr=%0d cyc=%0d exc=%b want 2/4/0", r_ntr, r_done_cyc, r_exc);
        else n_pass++;
        n_checks++;
        if (tr_addr[0] !== 32'h300 || tr_be[0] !== 4'b1110 || tr_wdata[0] !== 32'hBBCCDD00)
            $display("FAIL sw_split_first got %h/%b/%h want 300/1110/bbccdd00", tr_addr[0], tr_be[0], tr_wdata[0]);
        else n_pass++;
        n_checks++;
        if (tr_addr[1] !== 32'h304 || tr_be[1] !== 4'b0001 || tr_wdata[1] !== 32'h000000AA)
            $display("FAIL sw_split_second got %h/%b/%h want 304/0001/000000aa", tr_addr[1], tr_be[1], tr_wdata[1]);
        else n_pass++;
`else
        n_checks++;
        if (r_exc !== 1'b1 || r_done_cyc !== 2)
            $display("FAIL sw_trap got exc=%b cyc=%0d want 1/2", r_exc, r_done_cyc);
        else n_pass++;
        n_checks++;
        if (r_req_cycles !== 0 || r_rdata !== 32'd0)
            $display("FAIL sw_trap_quiet got req_cycles=%0d rdata=%h want 0/0", r_req_cycles, r_rdata);
        else n_pass++;
`endif
        n_checks++; if (r_viol !== 0) $display("FAIL sw_misalign_protocol got viol=%0d want 0", r_viol); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bad;
        rd_en_in = 1'b1; mem_size_in = 2'b10; sz_ex_in = 1'b0; addr_in = 32'h100;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1) $display("FAIL rst_pre_req got %b want 1", mem_req); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_req1_drop got %b want 0", mem_req); else n_pass++;
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || done_out !== 1'b0 || rdata_out !== 32'd0)
            $display("FAIL rst_wait1 got req=%b done=%b rdata=%h want 0/0/0", mem_req, done_out, rdata_out);
        else n_pass++;
        rd_en_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_out !== 1'b0 || mem_req !== 1'b0 || rdata_out !== 32'd0) bad++;
        end
        mem_rvalid = 1'b0;
        n_checks++; if (bad !== 0) $display("FAIL rst_late_rvalid got %0d bad cycles want 0", bad); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back(input int n);
        for (int k = 0; k < n; k++) begin
            logic        we, sx, mis, trap;
            logic [1:0]  sz;
            logic [31:0] a, wd, expv;
            logic [63:0] v;
            int          g, r, nb, beats, edone;
            we = 1'($urandom % 2); sx = 1'($urandom % 2); sz = 2'($urandom % 4);
            a = $urandom_range(0, 1015); wd = $urandom;
            g = $urandom_range(0, 2); r = $urandom_range(1, 3);
            nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            mis = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`ifdef DMEM_MISALIGN_EN
            trap = 1'b0;
`else
            trap = mis;
`endif
            beats = (int'(a[1:0]) + nb > 4) ? 2 : 1;
            v = 64'd0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = bmem[a[9:0] + i];
            if (sx && v[8*nb-1]) for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
            expv = v[31:0];
            edone = trap ? 2 : 2 + beats * (g + 1 + (we ? 0 : r));
            do_access(we, sz, sx, a, wd, g, r);
            n_checks++;
            if (r_done_cyc !== edone || r_exc !== trap)
                $display("FAIL rnd%0d_timing a=%h sz=%0d we=%b got cyc=%0d exc=%b want %0d/%b", k, a, sz, we, r_done_cyc, r_exc, edone, trap);
            else n_pass++;
            n_checks++;
            if (r_ntr !== (trap ? 0 : beats) || r_viol !== 0)
                $display("FAIL rnd%0d_bus a=%h sz=%0d got beats=%0d viol=%0d want %0d/0", k, a, sz, r_ntr, r_viol, trap ? 0 : beats);
            else n_pass++;
            if (!we || trap) begin
                n_checks++;
                if (r_rdata !== ((we || trap) ? 32'd0 : expv))
                    $display("FAIL rnd%0d_rdata a=%h sz=%0d sx=%b got %h want %h", k, a, sz, sx, r_rdata, (we || trap) ? 32'd0 : expv);
                else n_pass++;
            end
            if (we && !trap) model_store(a, nb, wd);
        end
    endtask

    task automatic test_memory_image();
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (wmem[i] !== {bmem[4*i+3], bmem[4*i+2], bmem[4*i+1], bmem[4*i]}) bad++;
        n_checks++; if (bad !== 0) $display("FAIL mem_image got %0d differing words want 0", bad); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) set_word(32'(i * 4), $urandom);
        test_reset();
        test_aligned_load();
        test_byte_extend();
        test_half_store();
        test_misaligned_store();
        test_reset_mid();
        test_back_to_back(200);
        test_memory_image();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
